// File: rtl/eeprom_arbiter_if.sv
// Bus between the arbiter and the EEPROM serial master: start pulses, address/data
// out, completion pulse and read byte back.
interface eeprom_arbiter_if;
    logic        EE_WR;
    logic        EE_RD;
    logic [10:0] EE_ADDR;
    logic [7:0]  EE_WDATA;
    logic        EE_ACK;
    logic [7:0]  EE_RDATA;

    modport master (
        output EE_WR, EE_RD, EE_ADDR, EE_WDATA,
        input  EE_ACK, EE_RDATA
    );

    modport slave (
        input  EE_WR, EE_RD, EE_ADDR, EE_WDATA,
        output EE_ACK, EE_RDATA
    );
endinterface

// File: rtl/eeprom_arbiter.sv
// Two-port round-robin arbiter in front of a single EEPROM serial master, with
// an ack timeout and a post-write idle gap.
module eeprom_arbiter #(
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned WR_GAP  = 1024
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  REQ0,
    input  logic                  REQ1,
    input  logic                  WE0,
    input  logic                  WE1,
    input  logic [10:0]           ADDR0,
    input  logic [10:0]           ADDR1,
    input  logic [7:0]            WDATA0,
    input  logic [7:0]            WDATA1,
    output logic                  DONE0,
    output logic                  DONE1,
    output logic                  ERR,
    output logic [7:0]            RDATA,
    output logic                  BUSY,
    output logic [2:0]            state_dbg,
    eeprom_arbiter_if.master      ee
);

    // Handshakes: REQn is a level held until its one-cycle DONEn pulse; EE_WR/EE_RD
    // are one-cycle start pulses and EE_ACK is a one-cycle completion pulse that
    // only counts while waiting for it.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);
    localparam logic [15:0] WR_GAP_M1  = 16'(WR_GAP - 1);

    logic [2:0]  state;
    logic [15:0] cnt;
    logic        cur_port;
    logic        cur_we;
    logic        last_port;
    logic        grant1;

    // Port 1 wins if it is the only requester, or if both request and 0 was served last.
    assign grant1    = REQ1 & (~REQ0 | ~last_port);
    assign state_dbg = state;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= S_IDLE;
            cnt         <= 16'd0;
            cur_port    <= 1'b0;
            cur_we      <= 1'b0;
            last_port   <= 1'b1;
            DONE0       <= 1'b0;
            DONE1       <= 1'b0;
            ERR         <= 1'b0;
            RDATA       <= 8'h00;
            BUSY        <= 1'b0;
            ee.EE_WR    <= 1'b0;
            ee.EE_RD    <= 1'b0;
            ee.EE_ADDR  <= 11'd0;
            ee.EE_WDATA <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (REQ0 || REQ1) begin
                        cur_port    <= grant1;
                        cur_we      <= grant1 ? WE1 : WE0;
                        ee.EE_ADDR  <= grant1 ? ADDR1 : ADDR0;
                        ee.EE_WDATA <= grant1 ? WDATA1 : WDATA0;
                        ee.EE_WR    <= grant1 ? WE1 : WE0;
                        ee.EE_RD    <= grant1 ? ~WE1 : ~WE0;
                        BUSY        <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    ee.EE_WR <= 1'b0;
                    ee.EE_RD <= 1'b0;
                    cnt      <= 16'd0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // A late ack on the final counted cycle still counts as success.
                    if (ee.EE_ACK) begin
                        ERR   <= 1'b0;
                        DONE0 <= ~cur_port;
                        DONE1 <= cur_port;
                        if (!cur_we) RDATA <= ee.EE_RDATA;
                        state <= S_DONE;
                    end else if (cnt == TIMEOUT_M1) begin
                        ERR   <= 1'b1;
                        DONE0 <= ~cur_port;
                        DONE1 <= cur_port;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_DONE: begin
                    DONE0     <= 1'b0;
                    DONE1     <= 1'b0;
                    ERR       <= 1'b0;
                    last_port <= cur_port;
                    cnt       <= 16'd0;
                    if (cur_we && !ERR && (WR_GAP > 0)) begin
                        state <= S_GAP;
                    end else begin
                        BUSY  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_GAP: begin
                    if (cnt == WR_GAP_M1) begin
                        BUSY  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eeprom_arbiter.sv
// Scoreboard bench for eeprom_arbiter: directed transactions on a default-sized
// instance and on a short-timeout instance.
module tb_eeprom_arbiter;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RESET;
    logic        REQ0, REQ1, WE0, WE1;
    logic [10:0] ADDR0, ADDR1;
    logic [7:0]  WDATA0, WDATA1;
    logic        DONE0, DONE1, ERR, BUSY;
    logic [7:0]  RDATA;
    logic [2:0]  state_a;

    logic        b_req0, b_req1, b_we0, b_we1;
    logic [10:0] b_addr0, b_addr1;
    logic [7:0]  b_wdata0, b_wdata1;
    logic        b_done0, b_done1, b_err, b_busy;
    logic [7:0]  b_rdata;
    logic [2:0]  state_b;

    eeprom_arbiter_if ee_a ();
    eeprom_arbiter_if ee_b ();

    eeprom_arbiter dut_a (
        .CLK(CLK), .RESET(RESET),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .DONE0(DONE0), .DONE1(DONE1), .ERR(ERR), .RDATA(RDATA), .BUSY(BUSY),
        .state_dbg(state_a), .ee(ee_a)
    );

    eeprom_arbiter #(.TIMEOUT(16), .WR_GAP(4)) dut_b (
        .CLK(CLK), .RESET(RESET),
        .REQ0(b_req0), .REQ1(b_req1), .WE0(b_we0), .WE1(b_we1),
        .ADDR0(b_addr0), .ADDR1(b_addr1), .WDATA0(b_wdata0), .WDATA1(b_wdata1),
        .DONE0(b_done0), .DONE1(b_done1), .ERR(b_err), .RDATA(b_rdata), .BUSY(b_busy),
        .state_dbg(state_b), .ee(ee_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Expected DONE: {port, err, rdata}; expected issue: {we, addr, wdata}.
    logic [9:0]  exp_q[$];
    logic [19:0] iss_q[$];
    logic [9:0]  exp_b_q[$];
    logic [19:0] iss_b_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: expired or unexpected", name);
    endtask

    // ---------------- monitors ----------------
    always @(negedge CLK) begin : mon_done_a
        logic [9:0] e;
        if (!RESET && (DONE0 || DONE1)) begin
            if (exp_q.size() == 0) fail_now("done_a_unexpected");
            else begin
                e = exp_q.pop_front();
                check("done_a", {21'd0, DONE0, DONE1, ERR, RDATA}, {21'd0, ~e[9], e[9:0]});
            end
        end
    end

    always @(negedge CLK) begin : mon_issue_a
        logic [19:0] e;
        if (!RESET && (ee_a.EE_WR || ee_a.EE_RD)) begin
            if (iss_q.size() == 0) fail_now("issue_a_unexpected");
            else begin
                e = iss_q.pop_front();
                check("issue_a", {11'd0, ee_a.EE_WR, ee_a.EE_RD, ee_a.EE_ADDR, ee_a.EE_WDATA},
                      {11'd0, e[19], ~e[19], e[18:0]});
            end
        end
    end

    always @(negedge CLK) begin : mon_done_b
        logic [9:0] e;
        if (!RESET && (b_done0 || b_done1)) begin
            if (exp_b_q.size() == 0) fail_now("done_b_unexpected");
            else begin
                e = exp_b_q.pop_front();
                check("done_b", {21'd0, b_done0, b_done1, b_err, b_rdata}, {21'd0, ~e[9], e[9:0]});
            end
        end
    end

    always @(negedge CLK) begin : mon_issue_b
        logic [19:0] e;
        if (!RESET && (ee_b.EE_WR || ee_b.EE_RD)) begin
            if (iss_b_q.size() == 0) fail_now("issue_b_unexpected");
            else begin
                e = iss_b_q.pop_front();
                check("issue_b", {11'd0, ee_b.EE_WR, ee_b.EE_RD, ee_b.EE_ADDR, ee_b.EE_WDATA},
                      {11'd0, e[19], ~e[19], e[18:0]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_issue(input bit b, output int at);
        bit seen = 1'b0;
        at = -1;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge CLK);
            if (b ? (ee_b.EE_WR || ee_b.EE_RD) : (ee_a.EE_WR || ee_a.EE_RD)) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
        if (!seen) fail_now("issue_timeout");
    endtask

    task automatic wait_done(input bit b, input int limit, output int at);
        bit seen = 1'b0;
        at = -1;
        for (int n = 0; n < limit && !seen; n++) begin
            @(negedge CLK);
            if (b ? (b_done0 || b_done1) : (DONE0 || DONE1)) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
        if (!seen) fail_now("done_timeout");
    endtask

    task automatic ack_after(input bit b, input int n, input logic [7:0] d);
        repeat (n) @(posedge CLK);
        #1;
        if (b) begin ee_b.EE_ACK = 1'b1; ee_b.EE_RDATA = d; end
        else   begin ee_a.EE_ACK = 1'b1; ee_a.EE_RDATA = d; end
        @(posedge CLK);
        #1;
        ee_a.EE_ACK = 1'b0;
        ee_b.EE_ACK = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [7:0] alt_rd [4];
        int ti, td, n;
        bit any_done;
        alt_rd[0] = 8'hA1; alt_rd[1] = 8'hB2; alt_rd[2] = 8'hC3; alt_rd[3] = 8'hD4;

        RESET = 1'b0;
        REQ0 = 0; REQ1 = 0; WE0 = 0; WE1 = 0;
        ADDR0 = 0; ADDR1 = 0; WDATA0 = 0; WDATA1 = 0;
        b_req0 = 0; b_req1 = 0; b_we0 = 0; b_we1 = 0;
        b_addr0 = 0; b_addr1 = 0; b_wdata0 = 0; b_wdata1 = 0;
        ee_a.EE_ACK = 0; ee_a.EE_RDATA = 0;
        ee_b.EE_ACK = 0; ee_b.EE_RDATA = 0;
        do_reset();

        @(negedge CLK);
        check("rst_busy",   {31'd0, BUSY}, 0);
        check("rst_done",   {30'd0, DONE0, DONE1}, 0);
        check("rst_err",    {31'd0, ERR}, 0);
        check("rst_ee_str", {30'd0, ee_a.EE_WR, ee_a.EE_RD}, 0);
        check("rst_ee_addr", {21'd0, ee_a.EE_ADDR}, 0);
        check("rst_ee_wdat", {24'd0, ee_a.EE_WDATA}, 0);
        check("rst_rdata",  {24'd0, RDATA}, 0);
        check("rst_state",  {29'd0, state_a}, 0);

        // Both requesters rise together and hold: grants 0,1,0,1.
        ADDR0 = 11'h100; WDATA0 = 8'h11; WE0 = 0;
        ADDR1 = 11'h200; WDATA1 = 8'h22; WE1 = 0;
        for (int i = 0; i < 4; i++) begin
            iss_q.push_back((i % 2 == 0) ? {1'b0, 11'h100, 8'h11} : {1'b0, 11'h200, 8'h22});
            exp_q.push_back({(i % 2 == 1), 1'b0, alt_rd[i]});
        end
        @(posedge CLK); #1 REQ0 = 1; REQ1 = 1;
        for (int i = 0; i < 4; i++) begin
            wait_issue(0, ti);
            ack_after(0, 5, alt_rd[i]);
            wait_done(0, 100, td);
            if (i == 3) begin REQ0 = 0; REQ1 = 0; end
        end

        // Stray ack while idle must do nothing.
        @(posedge CLK); #1 ee_a.EE_ACK = 1; ee_a.EE_RDATA = 8'hFF;
        @(posedge CLK); #1 ee_a.EE_ACK = 0;
        @(negedge CLK);
        check("idle_ack_busy",  {31'd0, BUSY}, 0);
        check("idle_ack_rdata", {24'd0, RDATA}, 32'hD4);

        // Write on port 0, ack after 40 cycles, then a 1024-cycle gap.
        WE0 = 1; ADDR0 = 11'h5A3; WDATA0 = 8'hC7;
        iss_q.push_back({1'b1, 11'h5A3, 8'hC7});
        exp_q.push_back({1'b0, 1'b0, 8'hD4});
        @(posedge CLK); #1 REQ0 = 1;
        wait_issue(0, ti);
        ADDR0 = 11'h7FF; WDATA0 = 8'h00;
        ack_after(0, 40, 8'h99);
        wait_done(0, 200, td);
        check("wr_addr_held",  {21'd0, ee_a.EE_ADDR}, 32'h5A3);
        check("wr_wdata_held", {24'd0, ee_a.EE_WDATA}, 32'hC7);
        REQ0 = 0;
        // Port 1 requests during the gap; it must wait for the gap to end.
        WE1 = 0; ADDR1 = 11'h012; WDATA1 = 8'h55;
        iss_q.push_back({1'b0, 11'h012, 8'h55});
        exp_q.push_back({1'b1, 1'b0, 8'h3E});
        REQ1 = 1;
        n = 0;
        begin : gap_count
            for (int k = 0; k < 2000; k++) begin
                @(negedge CLK);
                if (!BUSY) disable gap_count;
                n++;
            end
        end
        check("gap_len", n, 1024);

        // Read on port 1: no gap afterwards.
        wait_issue(0, ti);
        ack_after(0, 7, 8'h3E);
        wait_done(0, 100, td);
        check("rd_latency", td - ti, 8);
        REQ1 = 0;
        @(negedge CLK);
        check("rd_no_gap_state", {29'd0, state_a}, 0);
        check("rd_no_gap_busy",  {31'd0, BUSY}, 0);

        // Reset in the middle of a wait abandons the transaction.
        WE0 = 0; ADDR0 = 11'h333; WDATA0 = 8'h44;
        iss_q.push_back({1'b0, 11'h333, 8'h44});
        @(posedge CLK); #1 REQ0 = 1;
        wait_issue(0, ti);
        repeat (5) @(posedge CLK);
        #1 RESET = 1; REQ0 = 0;
        @(posedge CLK); #1 RESET = 0;
        @(negedge CLK);
        check("mid_rst_busy",  {31'd0, BUSY}, 0);
        check("mid_rst_state", {29'd0, state_a}, 0);
        check("mid_rst_rdata", {24'd0, RDATA}, 0);
        @(posedge CLK); #1 ee_a.EE_ACK = 1; ee_a.EE_RDATA = 8'h77;
        @(posedge CLK); #1 ee_a.EE_ACK = 0;
        any_done = 0;
        repeat (10) begin
            @(negedge CLK);
            if (DONE0 || DONE1) any_done = 1;
        end
        check("mid_rst_no_done", {31'd0, any_done}, 0);

        WE1 = 0; ADDR1 = 11'h444; WDATA1 = 8'h66;
        iss_q.push_back({1'b0, 11'h444, 8'h66});
        exp_q.push_back({1'b1, 1'b0, 8'h99});
        @(posedge CLK); #1 REQ1 = 1;
        wait_issue(0, ti);
        ack_after(0, 3, 8'h99);
        wait_done(0, 100, td);
        check("post_rst_latency", td - ti, 4);
        REQ1 = 0;

        // Short-timeout instance: ack on the last counted cycle still succeeds.
        b_we0 = 0; b_addr0 = 11'h0AB; b_wdata0 = 8'h12;
        iss_b_q.push_back({1'b0, 11'h0AB, 8'h12});
        exp_b_q.push_back({1'b0, 1'b0, 8'h5C});
        @(posedge CLK); #1 b_req0 = 1;
        wait_issue(1, ti);
        ack_after(1, 16, 8'h5C);
        wait_done(1, 100, td);
        b_req0 = 0;
        check("ack_at_limit_latency", td - ti, 17);

        // No ack at all: timeout after 16 wait cycles, RDATA kept.
        iss_b_q.push_back({1'b0, 11'h0AB, 8'h12});
        exp_b_q.push_back({1'b0, 1'b1, 8'h5C});
        ee_b.EE_RDATA = 8'hEE;
        repeat (2) @(posedge CLK);
        #1 b_req0 = 1;
        wait_issue(1, ti);
        wait_done(1, 100, td);
        b_req0 = 0;
        check("timeout_latency", td - ti, 17);
        @(negedge CLK);
        check("timeout_err_clear", {31'd0, b_err}, 0);
        check("timeout_rdata_kept", {24'd0, b_rdata}, 32'h5C);

        repeat (5) @(negedge CLK);
        check("exp_q_empty",   exp_q.size(), 0);
        check("iss_q_empty",   iss_q.size(), 0);
        check("exp_b_q_empty", exp_b_q.size(), 0);
        check("iss_b_q_empty", iss_b_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eeprom_arbiter.md
EEPROM_ARBITER -- requirements
Module: eeprom_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 4096, meaning the maximum number of CLK cycles to wait for EE_ACK before aborting (range 1..65535).
REQ-002 SHALL have parameter WR_GAP, default 1024, meaning the number of idle CLK cycles enforced after a successful write (range 0..65535).
REQ-003 SHALL have port CLK, input, 1, system clock; all logic on rising edge.
REQ-004 SHALL have port RESET, input, 1, synchronous, active-high reset.
REQ-005 SHALL have ports REQ0/REQ1, input, 1 each, level request from requester 0/1, held until its DONE pulse.
REQ-006 SHALL have ports WE0/WE1, input, 1 each, 1 = write, 0 = read.
REQ-007 SHALL have ports ADDR0/ADDR1, input, 11 each, EEPROM byte address.
REQ-008 SHALL have ports WDATA0/WDATA1, input, 8 each, write byte.
REQ-009 SHALL have ports DONE0/DONE1, output, 1 each, one-cycle completion pulse to requester 0/1.
REQ-010 SHALL have port ERR, output, 1, timeout flag, valid only while DONE0 or DONE1 is high.
REQ-011 SHALL have port RDATA, output, 8, read byte, valid while a DONE pulse for a read is high and held until the next capture.
REQ-012 SHALL have port BUSY, output, 1, high in every state except IDLE.
REQ-013 SHALL have ports EE_WR/EE_RD, output, 1 each, start pulses to the EEPROM serial master.
REQ-014 SHALL have ports EE_ADDR (11 bits) and EE_WDATA (8 bits), output, address and write byte to the EEPROM master.
REQ-015 SHALL have ports EE_ACK (1 bit) and EE_RDATA (8 bits), input, completion pulse and read byte from the EEPROM master.

Function
REQ-016 SHALL implement states IDLE, ISSUE, WAIT, DONE and GAP, all with registered outputs.
REQ-017 In IDLE with at least one REQ high, SHALL pick one requester, latch its WE/ADDR/WDATA into internal registers, and go to ISSUE on the next edge.
REQ-018 Arbitration SHALL be round-robin: when both REQ are high, the port not served last wins; after reset port 0 has priority.
REQ-019 In ISSUE, SHALL drive EE_WR (write) or EE_RD (read) high for exactly one cycle, never both, then go to WAIT.
REQ-020 EE_ADDR and EE_WDATA SHALL hold the latched values from ISSUE through DONE; requester input changes during that time SHALL be ignored.
REQ-021 In WAIT, a 16-bit counter SHALL increment each cycle from 0; EE_ACK=1 SHALL move the FSM to DONE with ERR=0, and on a read SHALL capture EE_RDATA into RDATA.
REQ-022 If the counter reaches TIMEOUT-1 with no EE_ACK, SHALL go to DONE with ERR=1 and leave RDATA unchanged; EE_ACK arriving in that same cycle SHALL take precedence (success).
REQ-023 In DONE, SHALL pulse DONEn of the served port for one cycle and record that port as last-served.
REQ-024 From DONE, SHALL go to GAP after a successful write when WR_GAP>0, otherwise to IDLE.
REQ-025 GAP SHALL last exactly WR_GAP cycles, with no arbitration and no EE_WR/EE_RD, then go to IDLE.
REQ-026 EE_ACK outside WAIT SHALL be ignored.
REQ-027 A requester that keeps REQ high in the cycle after its DONE SHALL be treated as a new request, subject to round-robin.
REQ-028 Latency: REQ sampled in IDLE at edge t -> EE_WR/EE_RD high in cycle t+1 -> EE_ACK at edge t+1+k -> DONE pulse in cycle t+2+k.

Reset
REQ-029 On RESET=1 at a rising edge, SHALL set the state to IDLE, clear counters, and set DONE0, DONE1, ERR, EE_WR, EE_RD and BUSY to 0, EE_ADDR to 0, EE_WDATA to 0, RDATA to 0x00, and last-served to port 1.
REQ-030 RESET in any state, including mid-WAIT and mid-GAP, SHALL abandon the transaction with no DONE pulse.

Verification
REQ-031 Write REQ0, WE0=1, ADDR0=0x5A3, WDATA0=0xC7, EE_ACK after 40 cycles -> one EE_WR pulse with EE_ADDR=0x5A3 and EE_WDATA=0xC7; DONE0 with ERR=0; BUSY stays high for 1024 GAP cycles.
REQ-032 Read REQ1, WE1=0, ADDR1=0x012, EE_ACK with EE_RDATA=0x3E -> one EE_RD pulse; DONE1 with RDATA=0x3E and ERR=0; next state IDLE with no GAP.
REQ-033 REQ0 and REQ1 rise together after reset and both stay high -> grant order 0,1,0,1; DONE pulses alternate.
REQ-034 Read with no EE_ACK, TIMEOUT=16 -> DONE pulse 16 cycles after entering WAIT with ERR=1 and RDATA unchanged.
REQ-035 RESET asserted mid-WAIT, then EE_ACK -> no DONE pulse; BUSY=0 the cycle after reset; a following request is served normally.
